sram_arbiter: RTL and testbench
===============================

Name: sram_arbiter

Overview:
- Two-port arbiter and access sequencer for the shared 1Mx16 external SRAM.
- Port 0 is the CPU memory path (MAR/MDR side). Port 1 is an auxiliary requester, such as a video or sprite fetch engine.
- Grants one access at a time using round-robin, and drives the active-low SRAM strobes over a fixed-length access window.
- Returns read data and a one-cycle Ack to the winning port. Sits between the requesters and the SRAM tristate buffer.

Parameters:
- ADDR_W, 20, SRAM address width.
- DATA_W, 16, SRAM data width.
- WAIT_CYCLES, 2, number of cycles the strobes are held active per access. Must be >= 1.

Ports:
- Clk  in  1  system clock; all logic on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- Req0  in  1  port 0 request; level, held until Ack0.
- We0  in  1  port 0 write enable (1 = write, 0 = read).
- Addr0  in  ADDR_W  port 0 address.
- Wdata0  in  DATA_W  port 0 write data.
- Ack0  out  1  port 0 completion pulse.
- Rdata0  out  DATA_W  port 0 read data.
- Req1, We1, Addr1, Wdata1, Ack1, Rdata1  same as port 0, for port 1.
- ADDR  out  ADDR_W  SRAM address.
- Data_Out  out  DATA_W  write data to the tristate buffer.
- Data_In  in  DATA_W  read data from the tristate buffer.
- CE, UB, LB, OE, WE  out  1 each  SRAM strobes, all active-low.

Behaviour:
- All outputs are registered.
- Reset (synchronous, active-high; clock Clk; polarity and synchronicity are fixed) sets:
  - state = IDLE, last_grant = 1, so port 0 wins the first tie.
  - Ack0 = Ack1 = 0; Rdata0 = Rdata1 = 0; ADDR = 0; Data_Out = 0.
  - CE = UB = LB = OE = WE = 1.
- State machine: IDLE -> ACCESS -> DONE -> IDLE.
- IDLE:
  - If no request is pending, stay in IDLE with all strobes at 1.
  - If only one request is pending, grant it.
  - If both are pending, grant the port != last_grant.
  - On the grant, latch Addr/We/Wdata of the winner into ADDR/Data_Out/op, set last_grant = winner, load count = WAIT_CYCLES-1, and go to ACCESS.
- ACCESS:
  - CE = UB = LB = 0.
  - Read: OE = 0, WE = 1.
  - Write: WE = 0, OE = 1, with Data_Out valid.
  - Decrement count each cycle. In the cycle where count == 0, a read captures Data_In into the winner's Rdata at the clock edge ending that cycle. Then go to DONE.
- DONE:
  - All strobes = 1, so WE rises before ADDR can change.
  - Winner's Ack = 1 for exactly this cycle. Go to IDLE.
- Timing: Req sampled in IDLE at cycle 0; ACCESS in cycles 1..WAIT_CYCLES; Ack in cycle WAIT_CYCLES+1. Minimum turnaround is WAIT_CYCLES+2 cycles per access.
- Ack0 and Ack1 are never high together, and never high outside DONE.
- Req still high in the IDLE cycle after Ack is treated as a new request.
- Req dropped mid-access: the access still completes and Ack still pulses.
- Address, write-data and We changes after the grant are ignored until the next grant.
- Rdata of a port holds its value until that port's next read completes. Writes and accesses by the other port do not alter it.
- Reset during ACCESS or DONE: abort at the next edge. No Ack is issued, strobes go to 1, and Rdata is reset to 0.
- Fairness: with both ports continuously requesting, grants alternate 0, 1, 0, 1. Neither port waits more than one access.

Test Plan:
- Reset, then port 0 read at Addr0 = 0x00010 (SRAM holds 0xBEEF), WAIT_CYCLES = 2 -> OE = 0 and CE = 0 in cycles 1–2, Ack0 in cycle 3, Rdata0 = 0xBEEF, Ack1 never asserted.
- Port 1 write Addr1 = 0x00020, Wdata1 = 0x1234, then port 1 read of the same address -> WE = 0 for exactly 2 cycles with Data_Out = 0x1234, WE = 1 in the DONE cycle, readback Rdata1 = 0x1234.
- Req0 and Req1 asserted in the same cycle out of reset and held for 4 accesses -> grant order 0, 1, 0, 1, one Ack per access, Acks 4 cycles apart.
- Port 0 reads 0xBEEF, then port 1 writes 0x5555 elsewhere -> Rdata0 stays 0xBEEF and Rdata1 stays 0.
- Req0 dropped in cycle 1 of a read, then a new Addr0 applied -> Ack0 still pulses in cycle 3 and ADDR keeps the latched address.
- Reset asserted in the second ACCESS cycle of a write -> next cycle has all strobes = 1, no Ack, state IDLE, and a tie afterwards grants port 0.

Source files
------------

// File: rtl/sram_arbiter.sv
// sram_arbiter
//
// Two-port round-robin arbiter and access sequencer for the shared 1Mx16
// external SRAM. Port 0 is the CPU memory path; port 1 is an auxiliary
// requester such as a video or sprite fetch engine. One access is granted
// at a time. The active-low SRAM strobes are held for WAIT_CYCLES cycles,
// and then the winning port gets a one-cycle Ack. Every output is a register.
//
// Ports:
//   Clk, Reset                 clock and synchronous active-high reset
//   Req0/We0/Addr0/Wdata0      port 0 request (level, held until Ack0)
//   Ack0/Rdata0                port 0 completion pulse and read data
//   Req1/We1/Addr1/Wdata1      port 1 request (level, held until Ack1)
//   Ack1/Rdata1                port 1 completion pulse and read data
//   ADDR, Data_Out             SRAM address and write data to the tristate buffer
//   Data_In                    read data from the tristate buffer
//   CE, UB, LB, OE, WE         SRAM strobes, all active-low
//
// Timing with the request sampled in IDLE at cycle 0:
//   cycles 1..WAIT_CYCLES  ACCESS (strobes active)
//   cycle WAIT_CYCLES+1    DONE (strobes released, Ack pulsed)

module sram_arbiter #(
  parameter int ADDR_W      = 20,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              Clk,
  input  logic              Reset,

  input  logic              Req0,
  input  logic              We0,
  input  logic [ADDR_W-1:0] Addr0,
  input  logic [DATA_W-1:0] Wdata0,
  output logic              Ack0,
  output logic [DATA_W-1:0] Rdata0,

  input  logic              Req1,
  input  logic              We1,
  input  logic [ADDR_W-1:0] Addr1,
  input  logic [DATA_W-1:0] Wdata1,
  output logic              Ack1,
  output logic [DATA_W-1:0] Rdata1,

  output logic [ADDR_W-1:0] ADDR,
  output logic [DATA_W-1:0] Data_Out,
  input  logic [DATA_W-1:0] Data_In,
  output logic              CE,
  output logic              UB,
  output logic              LB,
  output logic              OE,
  output logic              WE
);

  // The counter only has to hold WAIT_CYCLES-1 down to 0. It is kept at
  // least 1 bit wide so that WAIT_CYCLES = 1 still elaborates.
  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t             state;
  logic               last_grant;
  logic               winner;
  logic               op_write;
  logic [CNT_W-1:0]   count;

  logic               pick_valid;
  logic               pick_port;
  logic               pick_we;
  logic [ADDR_W-1:0]  pick_addr;
  logic [DATA_W-1:0]  pick_wdata;

  // Round-robin choice. On a tie, the port that did not win last time is
  // granted. If only one port is requesting, that port wins.
  always_comb begin
    pick_valid = Req0 | Req1;
    pick_port  = 1'b0;
    if (Req0 && Req1) begin
      pick_port = ~last_grant;
    end else if (Req1) begin
      pick_port = 1'b1;
    end

    pick_we    = We0;
    pick_addr  = Addr0;
    pick_wdata = Wdata0;
    if (pick_port) begin
      pick_we    = We1;
      pick_addr  = Addr1;
      pick_wdata = Wdata1;
    end
  end

  // Sequencer. The strobes are registered. They are set up on the grant
  // edge, so they are already active in the first ACCESS cycle. They are
  // released on the edge that enters DONE. WE therefore goes high a full
  // cycle before ADDR can be reloaded in the following IDLE.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      winner     <= 1'b0;
      op_write   <= 1'b0;
      count      <= '0;
      Ack0       <= 1'b0;
      Ack1       <= 1'b0;
      Rdata0     <= '0;
      Rdata1     <= '0;
      ADDR       <= '0;
      Data_Out   <= '0;
      CE         <= 1'b1;
      UB         <= 1'b1;
      LB         <= 1'b1;
      OE         <= 1'b1;
      WE         <= 1'b1;
    end else begin
      Ack0 <= 1'b0;
      Ack1 <= 1'b0;

      case (state)
        IDLE: begin
          if (pick_valid) begin
            ADDR       <= pick_addr;
            Data_Out   <= pick_wdata;
            op_write   <= pick_we;
            winner     <= pick_port;
            last_grant <= pick_port;
            count      <= CNT_INIT;
            CE         <= 1'b0;
            UB         <= 1'b0;
            LB         <= 1'b0;
            OE         <= pick_we;
            WE         <= ~pick_we;
            state      <= ACCESS;
          end
        end

        ACCESS: begin
          if (count == '0) begin
            // Data_In is valid in the last strobe cycle. Only the
            // winner's read register is loaded, so the other port's
            // data stays untouched.
            if (!op_write) begin
              if (winner) begin
                Rdata1 <= Data_In;
              end else begin
                Rdata0 <= Data_In;
              end
            end
            CE    <= 1'b1;
            UB    <= 1'b1;
            LB    <= 1'b1;
            OE    <= 1'b1;
            WE    <= 1'b1;
            Ack0  <= ~winner;
            Ack1  <= winner;
            state <= DONE;
          end else begin
            count <= count - 1'b1;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          CE    <= 1'b1;
          UB    <= 1'b1;
          LB    <= 1'b1;
          OE    <= 1'b1;
          WE    <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

  // Completion pulses are exclusive, and they only appear in DONE.
  assert property (@(posedge Clk) disable iff (Reset) !(Ack0 && Ack1));
  assert property (@(posedge Clk) disable iff (Reset) (Ack0 || Ack1) |-> (state == DONE));

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter
//
// Directed bench for sram_arbiter with WAIT_CYCLES = 2. A small SRAM model
// (256 words, indexed by ADDR[7:0]) serves reads and takes writes.
// Each scenario task drives its own stimulus and compares outputs one cycle
// at a time. Inputs change and outputs are sampled 1 time unit after the
// rising edge.

module tb_sram_arbiter;

  localparam int ADDR_W      = 20;
  localparam int DATA_W      = 16;
  localparam int WAIT_CYCLES = 2;

  localparam logic [4:0] STRB_IDLE  = 5'b11111;
  localparam logic [4:0] STRB_READ  = 5'b00001;
  localparam logic [4:0] STRB_WRITE = 5'b00010;

  logic              Clk;
  logic              Reset;
  logic              Req0, We0, Ack0;
  logic [ADDR_W-1:0] Addr0;
  logic [DATA_W-1:0] Wdata0, Rdata0;
  logic              Req1, We1, Ack1;
  logic [ADDR_W-1:0] Addr1;
  logic [DATA_W-1:0] Wdata1, Rdata1;
  logic [ADDR_W-1:0] ADDR;
  logic [DATA_W-1:0] Data_Out, Data_In;
  logic              CE, UB, LB, OE, WE;
  logic [4:0]        strb;

  int n_checks = 0;
  int n_fail   = 0;
  int ack0_cnt = 0;
  int ack1_cnt = 0;
  int overlap_cnt = 0;

  logic              sram_init;
  logic [DATA_W-1:0] mem [0:255];

  sram_arbiter #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .WAIT_CYCLES(WAIT_CYCLES)
  ) dut (
    .Clk(Clk), .Reset(Reset),
    .Req0(Req0), .We0(We0), .Addr0(Addr0), .Wdata0(Wdata0), .Ack0(Ack0), .Rdata0(Rdata0),
    .Req1(Req1), .We1(We1), .Addr1(Addr1), .Wdata1(Wdata1), .Ack1(Ack1), .Rdata1(Rdata1),
    .ADDR(ADDR), .Data_Out(Data_Out), .Data_In(Data_In),
    .CE(CE), .UB(UB), .LB(LB), .OE(OE), .WE(WE)
  );

  assign strb = {CE, UB, LB, OE, WE};

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // SRAM model: asynchronous read while CE and OE are low, and a write on
  // every edge while CE and WE are low.
  assign Data_In = (!CE && !OE) ? mem[ADDR[7:0]] : '0;

  always @(posedge Clk) begin
    if (sram_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
      mem[8'h10] <= 16'hBEEF;
    end else if (!CE && !WE) begin
      mem[ADDR[7:0]] <= Data_Out;
    end
  end

  // Ack bookkeeping, sampled away from the active edge.
  always @(negedge Clk) begin
    if (!Reset) begin
      if (Ack0) ack0_cnt++;
      if (Ack1) ack1_cnt++;
      if (Ack0 && Ack1) overlap_cnt++;
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1; sram_init = 1'b1;
    Req0 = 0; We0 = 0; Addr0 = '0; Wdata0 = '0;
    Req1 = 0; We1 = 0; Addr1 = '0; Wdata1 = '0;
    tick();
    sram_init = 1'b0;
    tick();
    n_checks++; if (strb !== STRB_IDLE) begin n_fail++; $display("[TB] FAIL reset_strobes: got %b expected %b", strb, STRB_IDLE); end
    n_checks++; if ({Ack0, Ack1} !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_acks: got %b expected 00", {Ack0, Ack1}); end
    n_checks++; if (Rdata0 !== 16'h0000) begin n_fail++; $display("[TB] FAIL reset_rdata0: got %h expected 0000", Rdata0); end
    n_checks++; if (Rdata1 !== 16'h0000) begin n_fail++; $display("[TB] FAIL reset_rdata1: got %h expected 0000", Rdata1); end
    n_checks++; if (ADDR !== 20'h00000) begin n_fail++; $display("[TB] FAIL reset_addr: got %h expected 00000", ADDR); end
    n_checks++; if (Data_Out !== 16'h0000) begin n_fail++; $display("[TB] FAIL reset_dout: got %h expected 0000", Data_Out); end
    Reset = 1'b0;
    tick();
    n_checks++; if (strb !== STRB_IDLE) begin n_fail++; $display("[TB] FAIL idle_no_req_strobes: got %b expected %b", strb, STRB_IDLE); end
  endtask

  task automatic test_port0_read();
    Addr0 = 20'h00010; We0 = 1'b0; Req0 = 1'b1;
    tick();
    n_checks++; if (strb !== STRB_READ) begin n_fail++; $display("[TB] FAIL rd0_strb_c1: got %b expected %b", strb, STRB_READ); end
    n_checks++; if (ADDR !== 20'h00010) begin n_fail++; $display("[TB] FAIL rd0_addr_c1: got %h expected 00010", ADDR); end
    n_checks++; if (Ack0 !== 1'b0) begin n_fail++; $display("[TB] FAIL rd0_ack_c1: got %b expected 0", Ack0); end
    tick();
    n_checks++; if (strb !== STRB_READ) begin n_fail++; $display("[TB] FAIL rd0_strb_c2: got %b expected %b", strb, STRB_READ); end
    n_checks++; if (Ack0 !== 1'b0) begin n_fail++; $display("[TB] FAIL rd0_ack_c2: got %b expected 0", Ack0); end
    tick();
    n_checks++; if ({Ack0, Ack1} !== 2'b10) begin n_fail++; $display("[TB] FAIL rd0_ack_c3: got %b expected 10", {Ack0, Ack1}); end
    n_checks++; if (strb !== STRB_IDLE) begin n_fail++; $display("[TB] FAIL rd0_strb_c3: got %b expected %b", strb, STRB_IDLE); end
    n_checks++; if (Rdata0 !== 16'hBEEF) begin n_fail++; $display("[TB] FAIL rd0_rdata: got %h expected beef", Rdata0); end
    Req0 = 1'b0;
    tick();
    n_checks++; if (Ack0 !== 1'b0) begin n_fail++; $display("[TB] FAIL rd0_ack_c4: got %b expected 0", Ack0); end
  endtask

  task automatic test_rdata_isolation();
    Addr1 = 20'h00040; We1 = 1'b1; Wdata1 = 16'h5555; Req1 = 1'b1;
    tick(); tick(); tick();
    n_checks++; if (Ack1 !== 1'b1) begin n_fail++; $display("[TB] FAIL iso_ack1: got %b expected 1", Ack1); end
    n_checks++; if (Rdata0 !== 16'hBEEF) begin n_fail++; $display("[TB] FAIL iso_rdata0: got %h expected beef", Rdata0); end
    n_checks++; if (Rdata1 !== 16'h0000) begin n_fail++; $display("[TB] FAIL iso_rdata1: got %h expected 0000", Rdata1); end
    Req1 = 1'b0; We1 = 1'b0;
    tick();
  endtask

  task automatic test_write_readback();
    Addr1 = 20'h00020; We1 = 1'b1; Wdata1 = 16'h1234; Req1 = 1'b1;
    tick();
    n_checks++; if (strb !== STRB_WRITE) begin n_fail++; $display("[TB] FAIL wr1_strb_c1: got %b expected %b", strb, STRB_WRITE); end
    n_checks++; if (Data_Out !== 16'h1234) begin n_fail++; $display("[TB] FAIL wr1_dout: got %h expected 1234", Data_Out); end
    n_checks++; if (ADDR !== 20'h00020) begin n_fail++; $display("[TB] FAIL wr1_addr: got %h expected 00020", ADDR); end
    tick();
    n_checks++; if (strb !== STRB_WRITE) begin n_fail++; $display("[TB] FAIL wr1_strb_c2: got %b expected %b", strb, STRB_WRITE); end
    tick();
    n_checks++; if (strb !== STRB_IDLE) begin n_fail++; $display("[TB] FAIL wr1_strb_done: got %b expected %b", strb, STRB_IDLE); end
    n_checks++; if ({Ack0, Ack1} !== 2'b01) begin n_fail++; $display("[TB] FAIL wr1_ack: got %b expected 01", {Ack0, Ack1}); end
    Req1 = 1'b0;
    tick();
    We1 = 1'b0; Wdata1 = '0; Req1 = 1'b1;
    tick();
    n_checks++; if (strb !== STRB_READ) begin n_fail++; $display("[TB] FAIL rd1_strb_c1: got %b expected %b", strb, STRB_READ); end
    tick(); tick();
    n_checks++; if (Ack1 !== 1'b1) begin n_fail++; $display("[TB] FAIL rd1_ack: got %b expected 1", Ack1); end
    n_checks++; if (Rdata1 !== 16'h1234) begin n_fail++; $display("[TB] FAIL rd1_rdata: got %h expected 1234", Rdata1); end
    n_checks++; if (Rdata0 !== 16'hBEEF) begin n_fail++; $display("[TB] FAIL rd1_rdata0_kept: got %h expected beef", Rdata0); end
    Req1 = 1'b0;
    tick();
  endtask

  task automatic test_req_drop();
    Addr0 = 20'h00010; We0 = 1'b0; Req0 = 1'b1;
    tick();
    Req0 = 1'b0; Addr0 = 20'h00030; We0 = 1'b1; Wdata0 = 16'hFFFF;
    n_checks++; if (ADDR !== 20'h00010) begin n_fail++; $display("[TB] FAIL drop_addr_c1: got %h expected 00010", ADDR); end
    tick();
    n_checks++; if (ADDR !== 20'h00010) begin n_fail++; $display("[TB] FAIL drop_addr_c2: got %h expected 00010", ADDR); end
    n_checks++; if (strb !== STRB_READ) begin n_fail++; $display("[TB] FAIL drop_strb_c2: got %b expected %b", strb, STRB_READ); end
    tick();
    n_checks++; if (Ack0 !== 1'b1) begin n_fail++; $display("[TB] FAIL drop_ack_c3: got %b expected 1", Ack0); end
    n_checks++; if (ADDR !== 20'h00010) begin n_fail++; $display("[TB] FAIL drop_addr_c3: got %h expected 00010", ADDR); end
    tick();
    n_checks++; if (Ack0 !== 1'b0) begin n_fail++; $display("[TB] FAIL drop_ack_c4: got %b expected 0", Ack0); end
    n_checks++; if (strb !== STRB_IDLE) begin n_fail++; $display("[TB] FAIL drop_strb_c4: got %b expected %b", strb, STRB_IDLE); end
    We0 = 1'b0; Wdata0 = '0;
  endtask

  task automatic test_reset_abort();
    Addr0 = 20'h00050; We0 = 1'b1; Wdata0 = 16'hAAAA; Req0 = 1'b1;
    tick();
    n_checks++; if (Data_Out !== 16'hAAAA) begin n_fail++; $display("[TB] FAIL abort_dout: got %h expected aaaa", Data_Out); end
    tick();
    n_checks++; if (strb !== STRB_WRITE) begin n_fail++; $display("[TB] FAIL abort_strb_c2: got %b expected %b", strb, STRB_WRITE); end
    Reset = 1'b1; Req0 = 1'b0;
    tick();
    n_checks++; if (strb !== STRB_IDLE) begin n_fail++; $display("[TB] FAIL abort_strobes: got %b expected %b", strb, STRB_IDLE); end
    n_checks++; if ({Ack0, Ack1} !== 2'b00) begin n_fail++; $display("[TB] FAIL abort_acks: got %b expected 00", {Ack0, Ack1}); end
    n_checks++; if (Rdata0 !== 16'h0000) begin n_fail++; $display("[TB] FAIL abort_rdata0: got %h expected 0000", Rdata0); end
    n_checks++; if (Rdata1 !== 16'h0000) begin n_fail++; $display("[TB] FAIL abort_rdata1: got %h expected 0000", Rdata1); end
    // Release reset and raise both requests together. This is a tie in IDLE.
    Reset = 1'b0;
    Addr0 = 20'h00010; We0 = 1'b0; Req0 = 1'b1;
    Addr1 = 20'h00020; We1 = 1'b0; Req1 = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic              exp_port;
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] exp_data;
    for (int k = 0; k < 4; k++) begin
      exp_port = k[0];
      exp_addr = exp_port ? 20'h00020 : 20'h00010;
      exp_data = exp_port ? 16'h1234 : 16'hBEEF;
      tick();
      n_checks++; if (ADDR !== exp_addr) begin n_fail++; $display("[TB] FAIL b2b_grant%0d_addr: got %h expected %h", k, ADDR, exp_addr); end
      n_checks++; if (strb !== STRB_READ) begin n_fail++; $display("[TB] FAIL b2b_grant%0d_strb: got %b expected %b", k, strb, STRB_READ); end
      tick();
      n_checks++; if ({Ack0, Ack1} !== 2'b00) begin n_fail++; $display("[TB] FAIL b2b_early_ack%0d: got %b expected 00", k, {Ack0, Ack1}); end
      tick();
      n_checks++; if ({Ack0, Ack1} !== {~exp_port, exp_port}) begin n_fail++; $display("[TB] FAIL b2b_ack%0d: got %b expected %b", k, {Ack0, Ack1}, {~exp_port, exp_port}); end
      n_checks++; if ((exp_port ? Rdata1 : Rdata0) !== exp_data) begin n_fail++; $display("[TB] FAIL b2b_rdata%0d: got %h expected %h", k, exp_port ? Rdata1 : Rdata0, exp_data); end
      if (k == 3) begin
        Req0 = 1'b0; Req1 = 1'b0;
      end
      tick();
      n_checks++; if (strb !== STRB_IDLE) begin n_fail++; $display("[TB] FAIL b2b_idle%0d_strb: got %b expected %b", k, strb, STRB_IDLE); end
    end
    tick();
    n_checks++; if (strb !== STRB_IDLE) begin n_fail++; $display("[TB] FAIL b2b_quiet_strb: got %b expected %b", strb, STRB_IDLE); end
  endtask

  initial begin
    $display("[TB] sram_arbiter directed test, WAIT_CYCLES=%0d", WAIT_CYCLES);
    test_reset();
    test_port0_read();
    test_rdata_isolation();
    test_write_readback();
    test_req_drop();
    test_reset_abort();
    test_back_to_back();
    tick();
    n_checks++; if (ack0_cnt !== 4) begin n_fail++; $display("[TB] FAIL ack0_total: got %0d expected 4", ack0_cnt); end
    n_checks++; if (ack1_cnt !== 5) begin n_fail++; $display("[TB] FAIL ack1_total: got %0d expected 5", ack1_cnt); end
    n_checks++; if (overlap_cnt !== 0) begin n_fail++; $display("[TB] FAIL ack_overlap: got %0d expected 0", overlap_cnt); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
